// File: rtl/lpc_host.sv
// lpc_host: LPC host bus engine. Issues single-byte I/O or TPM-locality read or
// write cycles, drives LFRAME#/LAD and decodes the peripheral's SYNC response.
// LAD is split into lad_o/lad_oe_o/lad_i; the integrating top level owns the tristate.
//
// Ports:
//   clk_i, nrst_i          LPC clock, asynchronous active-low reset
//   req_i, wr_i, tpm_i     request strobe and cycle kind, captured in IDLE
//   addr_i, data_i         cycle address and write data, captured in IDLE
//   busy_o, done_o, err_o  status; done_o is a one-cycle pulse, err_o valid with it
//   data_o                 read data, valid with done_o and held until the next accept
//   lframe_o, lad_o,
//   lad_oe_o, lad_i        LPC bus pins
//
// Parameter SYNC_TIMEOUT: SYNC cycles allowed before timeout (1..255).
// Macro LPC_HOST_ABORT_EN: when defined, a timeout issues an LFRAME# abort
// sequence before completing; otherwise the timeout completes directly.
module lpc_host #(
   parameter int unsigned SYNC_TIMEOUT = 32
) (
   input  logic        clk_i,
   input  logic        nrst_i,
   input  logic        req_i,
   input  logic        wr_i,
   input  logic        tpm_i,
   input  logic [15:0] addr_i,
   input  logic [7:0]  data_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [7:0]  data_o,
   output logic        lframe_o,
   output logic [3:0]  lad_o,
   output logic        lad_oe_o,
   input  logic [3:0]  lad_i
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_TIMEOUT - 1);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_CYCTYPE,
      ST_ADDR,
      ST_WDATA,
      ST_TAR_H,
      ST_SYNC,
      ST_RDATA,
      ST_TAR_P,
      ST_DONE
`ifdef LPC_HOST_ABORT_EN
      , ST_ABORT
      , ST_ABORT_END
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
   logic             wr_q, wr_d;
   logic             tpm_q, tpm_d;
   logic [15:0]      addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [7:0]       data_q, data_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             lframe_q, lframe_d;
   logic [3:0]       lad_q, lad_d;
   logic             lad_oe_q, lad_oe_d;

   // State and registered bus/status outputs.
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q    <= ST_IDLE;
         idx_q      <= 2'd0;
         sync_cnt_q <= '0;
         wr_q       <= 1'b0;
         tpm_q      <= 1'b0;
         addr_q     <= 16'h0000;
         wdata_q    <= 8'h00;
         data_q     <= 8'h00;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         lframe_q   <= 1'b1;
         lad_q      <= 4'hF;
         lad_oe_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         sync_cnt_q <= sync_cnt_d;
         wr_q       <= wr_d;
         tpm_q      <= tpm_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         data_q     <= data_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         lframe_q   <= lframe_d;
         lad_q      <= lad_d;
         lad_oe_q   <= lad_oe_d;
      end
   end

   // Next-state logic, then output decode from the next state so the pins
   // line up with the state they belong to.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      sync_cnt_d = sync_cnt_q;
      wr_d       = wr_q;
      tpm_d      = tpm_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      data_d     = data_q;
      err_d      = err_q;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      lframe_d   = 1'b1;
      lad_d      = 4'hF;
      lad_oe_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               state_d = ST_START;
               idx_d   = 2'd0;
               wr_d    = wr_i;
               tpm_d   = tpm_i;
               addr_d  = addr_i;
               wdata_d = data_i;
               err_d   = 1'b0;
            end
         end
         ST_START: state_d = ST_CYCTYPE;
         ST_CYCTYPE: begin
            state_d = ST_ADDR;
            idx_d   = 2'd0;
         end
         ST_ADDR: begin
            if (idx_q == 2'd3) begin
               idx_d   = 2'd0;
               state_d = wr_q ? ST_WDATA : ST_TAR_H;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         ST_WDATA: begin
            if (idx_q == 2'd1) begin
               idx_d   = 2'd0;
               state_d = ST_TAR_H;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         ST_TAR_H: begin
            if (idx_q == 2'd1) begin
               idx_d      = 2'd0;
               sync_cnt_d = '0;
               state_d    = ST_SYNC;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         ST_SYNC: begin
            sync_cnt_d = sync_cnt_q + CNT_W'(1);
            idx_d      = 2'd0;
            case (lad_i)
               4'b0000: state_d = wr_q ? ST_TAR_P : ST_RDATA;
               4'b0101, 4'b0110: begin
                  // Ready on the last allowed cycle still wins over timeout.
                  if (sync_cnt_q == SYNC_LAST) begin
                     err_d = 1'b1;
`ifdef LPC_HOST_ABORT_EN
                     state_d = ST_ABORT;
`else
                     state_d = ST_DONE;
`endif
                  end
               end
               default: begin
                  err_d   = 1'b1;
                  state_d = ST_TAR_P;
               end
            endcase
         end
         ST_RDATA: begin
            if (idx_q == 2'd0) begin
               data_d[3:0] = lad_i;
               idx_d       = 2'd1;
            end else begin
               data_d[7:4] = lad_i;
               idx_d       = 2'd0;
               state_d     = ST_TAR_P;
            end
         end
         ST_TAR_P: begin
            if (idx_q == 2'd1) begin
               idx_d   = 2'd0;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
`ifdef LPC_HOST_ABORT_EN
         ST_ABORT: begin
            if (idx_q == 2'd3) begin
               idx_d   = 2'd0;
               state_d = ST_ABORT_END;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         ST_ABORT_END: state_d = ST_DONE;
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d = (state_d == ST_DONE);

      case (state_d)
         ST_START: begin
            lframe_d = 1'b0;
            lad_oe_d = 1'b1;
            lad_d    = tpm_d ? 4'b0101 : 4'b0000;
         end
         ST_CYCTYPE: begin
            lad_oe_d = 1'b1;
            lad_d    = {2'b00, wr_q, 1'b0};
         end
         ST_ADDR: begin
            lad_oe_d = 1'b1;
            case (idx_d)
               2'd0:    lad_d = addr_q[15:12];
               2'd1:    lad_d = addr_q[11:8];
               2'd2:    lad_d = addr_q[7:4];
               default: lad_d = addr_q[3:0];
            endcase
         end
         ST_WDATA: begin
            lad_oe_d = 1'b1;
            lad_d    = (idx_d == 2'd0) ? wdata_q[3:0] : wdata_q[7:4];
         end
         // Drive 1111 for one cycle before releasing LAD to the peripheral.
         ST_TAR_H: lad_oe_d = (idx_d == 2'd0);
`ifdef LPC_HOST_ABORT_EN
         ST_ABORT: begin
            lframe_d = 1'b0;
            lad_oe_d = 1'b1;
         end
         ST_ABORT_END: lad_oe_d = 1'b1;
`endif
         default: ;
      endcase
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign err_o    = err_q;
   assign data_o   = data_q;
   assign lframe_o = lframe_q;
   assign lad_o    = lad_q;
   assign lad_oe_o = lad_oe_q;

endmodule

// File: tb/tb_lpc_host.sv
// tb_lpc_host: directed bench for lpc_host with a cycle-indexed peripheral model.
// Build with or without LPC_HOST_ABORT_EN; timeout expectations follow the macro.
module tb_lpc_host;

   localparam int unsigned TO = 4;

   logic        clk_i = 1'b0;
   logic        nrst_i;
   logic        req_i, wr_i, tpm_i;
   logic [15:0] addr_i;
   logic [7:0]  data_i;
   logic        busy_o, done_o, err_o;
   logic [7:0]  data_o;
   logic        lframe_o;
   logic [3:0]  lad_o;
   logic        lad_oe_o;
   logic [3:0]  lad_i;

   lpc_host #(.SYNC_TIMEOUT(TO)) dut (
      .clk_i   (clk_i),
      .nrst_i  (nrst_i),
      .req_i   (req_i),
      .wr_i    (wr_i),
      .tpm_i   (tpm_i),
      .addr_i  (addr_i),
      .data_i  (data_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .err_o   (err_o),
      .data_o  (data_o),
      .lframe_o(lframe_o),
      .lad_o   (lad_o),
      .lad_oe_o(lad_oe_o),
      .lad_i   (lad_i)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   // 5'h10 marks a released LAD in the trace.
   logic [4:0] tr_lad [0:47];
   int         lat;
   int         fr_low;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Runs one transaction starting #1 after a posedge with the DUT idle.
   // Peripheral answers n_wait x 0110, then sync_nib, then read nibbles rd[3:0], rd[7:4].
   task automatic run_cyc(input logic wr, input logic tpm, input logic [15:0] addr,
                          input logic [7:0] data, input logic [3:0] sync_nib,
                          input int n_wait, input logic [7:0] rd, input bit hold_req);
      int s0;
      int k;
      req_i  = 1'b1;
      wr_i   = wr;
      tpm_i  = tpm;
      addr_i = addr;
      data_i = data;
      lat    = -1;
      fr_low = 0;
      for (int i = 0; i < 48; i++) tr_lad[i] = 5'h1F;
      @(posedge clk_i);
      #1;
      if (!hold_req) req_i = 1'b0;
      addr_i = 16'hFFFF;
      data_i = 8'h00;
      s0 = wr ? 10 : 8;
      for (int e = 0; e < 48; e++) begin
         tr_lad[e] = lad_oe_o ? {1'b0, lad_o} : 5'h10;
         if (e > 0 && !lframe_o) fr_low++;
         if (done_o) begin
            lat = e;
            break;
         end
         k = e - s0;
         if (k >= 0 && k < n_wait)   lad_i = 4'h6;
         else if (k == n_wait)       lad_i = sync_nib;
         else if (k == n_wait + 1)   lad_i = rd[3:0];
         else if (k == n_wait + 2)   lad_i = rd[7:4];
         else                        lad_i = 4'hF;
         @(posedge clk_i);
         #1;
      end
      lad_i = 4'hF;
   endtask

   logic [4:0] exp1 [0:10];
   logic [4:0] exp2 [0:7];
   int         seen;

   initial begin
      nrst_i = 1'b0;
      req_i  = 1'b0;
      wr_i   = 1'b0;
      tpm_i  = 1'b0;
      addr_i = 16'h0000;
      data_i = 8'h00;
      lad_i  = 4'hF;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_busy",   32'(busy_o),   32'd0);
      check("rst_done",   32'(done_o),   32'd0);
      check("rst_err",    32'(err_o),    32'd0);
      check("rst_data",   32'(data_o),   32'h00);
      check("rst_lframe", 32'(lframe_o), 32'd1);
      check("rst_lad",    32'(lad_o),    32'hF);
      check("rst_oe",     32'(lad_oe_o), 32'd0);
      nrst_i = 1'b1;
      @(posedge clk_i);
      #1;

      // 1: TPM write 0024 <- A5, immediate ready
      exp1 = '{5'h05, 5'h02, 5'h00, 5'h00, 5'h02, 5'h04, 5'h05, 5'h0A, 5'h0F, 5'h10, 5'h10};
      run_cyc(1'b1, 1'b1, 16'h0024, 8'hA5, 4'h0, 0, 8'h00, 1'b0);
      for (int e = 0; e < 11; e++) check($sformatf("t1_lad%0d", e), 32'(tr_lad[e]), 32'(exp1[e]));
      check("t1_lat",  32'(lat),    32'd13);
      check("t1_err",  32'(err_o),  32'd0);
      check("t1_busy", 32'(busy_o), 32'd0);
      @(posedge clk_i);
      #1;
      check("t1_pulse", 32'(done_o), 32'd0);

      // 2: I/O read 0F00, three waits, data C3
      exp2 = '{5'h00, 5'h00, 5'h00, 5'h0F, 5'h00, 5'h00, 5'h0F, 5'h10};
      run_cyc(1'b0, 1'b0, 16'h0F00, 8'h00, 4'h0, 3, 8'hC3, 1'b0);
      for (int e = 0; e < 8; e++) check($sformatf("t2_lad%0d", e), 32'(tr_lad[e]), 32'(exp2[e]));
      check("t2_lat",  32'(lat),    32'd16);
      check("t2_data", 32'(data_o), 32'hC3);
      check("t2_err",  32'(err_o),  32'd0);
      @(posedge clk_i);
      #1;

      // 3: TPM read, SYNC error
      run_cyc(1'b0, 1'b1, 16'h1234, 8'h00, 4'hA, 0, 8'h5A, 1'b0);
      check("t3_start", 32'(tr_lad[0]), 32'h05);
      check("t3_lat",   32'(lat),    32'd11);
      check("t3_err",   32'(err_o),  32'd1);
      check("t3_data",  32'(data_o), 32'hC3);
      @(posedge clk_i);
      #1;

      // 4: SYNC stuck at long wait -> timeout after TO cycles
      run_cyc(1'b0, 1'b0, 16'h0080, 8'h00, 4'h6, 40, 8'h00, 1'b0);
      check("t4_err", 32'(err_o), 32'd1);
`ifdef LPC_HOST_ABORT_EN
      check("t4_lat",    32'(lat),    32'd17);
      check("t4_lframe", 32'(fr_low), 32'd4);
      for (int e = 12; e < 17; e++) check($sformatf("t4_abort_lad%0d", e), 32'(tr_lad[e]), 32'h0F);
`else
      check("t4_lat",    32'(lat),    32'd12);
      check("t4_lframe", 32'(fr_low), 32'd0);
      check("t4_lad12",  32'(tr_lad[11]), 32'h10);
`endif
      @(posedge clk_i);
      #1;

      // 5: req held, addr changed after accept; back-to-back restart
      run_cyc(1'b1, 1'b0, 16'h3C5A, 8'h11, 4'h0, 0, 8'h00, 1'b1);
      check("t5_a0", 32'(tr_lad[2]), 32'h03);
      check("t5_a1", 32'(tr_lad[3]), 32'h0C);
      check("t5_a2", 32'(tr_lad[4]), 32'h05);
      check("t5_a3", 32'(tr_lad[5]), 32'h0A);
      check("t5_lat", 32'(lat), 32'd13);
      @(posedge clk_i);
      #1;
      check("t5_idle_busy",   32'(busy_o),   32'd0);
      check("t5_idle_lframe", 32'(lframe_o), 32'd1);
      @(posedge clk_i);
      #1;
      req_i = 1'b0;
      check("t5_re_lframe", 32'(lframe_o), 32'd0);
      check("t5_re_busy",   32'(busy_o),   32'd1);
      seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         @(posedge clk_i);
         #1;
         if (done_o) seen = 1;
      end
      check("t5_re_done", 32'(seen), 32'd1);
      @(posedge clk_i);
      #1;

      // 6: reset during ADDR
      req_i  = 1'b1;
      wr_i   = 1'b0;
      tpm_i  = 1'b1;
      addr_i = 16'h0024;
      @(posedge clk_i);
      #1;
      req_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("t6_in_addr", 32'(tr_lad[0] !== 5'h1F && lad_oe_o && lframe_o), 32'd1);
      nrst_i = 1'b0;
      @(posedge clk_i);
      #1;
      check("t6_lframe", 32'(lframe_o), 32'd1);
      check("t6_oe",     32'(lad_oe_o), 32'd0);
      check("t6_busy",   32'(busy_o),   32'd0);
      nrst_i = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk_i);
         #1;
         if (done_o || busy_o) seen++;
      end
      check("t6_quiet", 32'(seen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
